// File: rtl/cclk_driver.sv
// cclk_driver: emits a cclk toggle burst, parks high, flags stable after a hold, drives low on release.
module cclk_driver #(
   parameter int CLK_RATE     = 50000000,
   parameter int CCLK_DIV     = 4,
   parameter int TOGGLE_COUNT = 16,
   parameter int HOLD_CYCLES  = CLK_RATE / 100000,
   parameter int LOW_CYCLES   = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic release_i,
   output logic cclk_o,
   output logic busy_o,
   output logic stable_o,
   output logic done_o
);
   localparam int DW = $clog2(CCLK_DIV + 1);
   localparam int RW = $clog2(TOGGLE_COUNT + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int LW = $clog2(LOW_CYCLES + 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CCLK_DIV - 1);
   localparam logic [RW-1:0] RISE_LAST = RW'(TOGGLE_COUNT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [LW-1:0] LOW_LAST  = LW'(LOW_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, TOGGLE, HOLD, HIGH, LOW} state_t;

   state_t state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [RW-1:0] rise_q, rise_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [LW-1:0] low_q, low_d;
   logic cclk_q, cclk_d, busy_q, busy_d, stable_q, stable_d, done_q, done_d;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= IDLE;
         div_q    <= '0;
         rise_q   <= '0;
         hold_q   <= '0;
         low_q    <= '0;
         cclk_q   <= 1'b0;
         busy_q   <= 1'b0;
         stable_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         rise_q   <= rise_d;
         hold_q   <= hold_d;
         low_q    <= low_d;
         cclk_q   <= cclk_d;
         busy_q   <= busy_d;
         stable_q <= stable_d;
         done_q   <= done_d;
      end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      rise_d  = rise_q;
      hold_d  = hold_q;
      low_d   = low_q;
      cclk_d  = cclk_q;
      case (state_q)
         IDLE: begin
            cclk_d = 1'b0;
            if (start_i) begin
               state_d = TOGGLE;
               div_d   = '0;
               rise_d  = '0;
            end
         end
         TOGGLE:
            if (release_i) state_d = LOW;
            else if (div_q == DIV_LAST) begin
               div_d  = '0;
               cclk_d = ~cclk_q;
               // the last rise parks the line high instead of scheduling another fall
               if (!cclk_q) begin
                  rise_d = rise_q + 1'b1;
                  if (rise_q == RISE_LAST) begin
                     state_d = HOLD;
                     rise_d  = '0;
                     hold_d  = '0;
                  end
               end
            end else div_d = div_q + 1'b1;
         HOLD: begin
            cclk_d = 1'b1;
            if (release_i) state_d = LOW;
            else if (hold_q == HOLD_LAST) begin
               state_d = HIGH;
               hold_d  = '0;
            end else hold_d = hold_q + 1'b1;
         end
         HIGH: begin
            cclk_d = 1'b1;
            if (release_i) state_d = LOW;
         end
         LOW: begin
            cclk_d = 1'b0;
            state_d = low_q == LOW_LAST ? IDLE : LOW;
            low_d   = low_q == LOW_LAST ? '0 : low_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == LOW && state_q != LOW) begin
         cclk_d = 1'b0;
         div_d  = '0;
         rise_d = '0;
         hold_d = '0;
         low_d  = '0;
      end
      busy_d   = state_d == TOGGLE || state_d == HOLD || state_d == LOW;
      stable_d = state_d == HIGH;
      done_d   = stable_d && state_q != HIGH;
   end

   assign cclk_o   = cclk_q;
   assign busy_o   = busy_q;
   assign stable_o = stable_q;
   assign done_o   = done_q;
endmodule

// File: tb/tb_cclk_driver.sv
// tb_cclk_driver: directed checks of burst, ready, release, abort, async reset and a peer readiness detector.
module tb_cclk_driver;
   localparam int PEER_HOLD = 10;

   logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, release_i = 1'b0;
   logic cclk_o, busy_o, stable_o, done_o;
   logic peer_ready = 1'b0;
   int   peer_cnt = 0;
   int   n_vec = 0, n_err = 0;

   cclk_driver #(
      .CLK_RATE(1000000), .CCLK_DIV(2), .TOGGLE_COUNT(3), .HOLD_CYCLES(8), .LOW_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .release_i(release_i),
      .cclk_o(cclk_o), .busy_o(busy_o), .stable_o(stable_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   // reference peer: ready after PEER_HOLD consecutive high samples, clears on any low sample
   always @(posedge clk or posedge rst)
      if (rst) begin
         peer_cnt   <= 0;
         peer_ready <= 1'b0;
      end else if (!cclk_o) begin
         peer_cnt   <= 0;
         peer_ready <= 1'b0;
      end else if (peer_cnt == PEER_HOLD - 1) peer_ready <= 1'b1;
      else peer_cnt <= peer_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // edge t0 is the start pulse; checks edges t0..t0+19
   task automatic run_burst();
      pulse_start();
      for (int e = 0; e < 20; e++) begin
         if (e > 0) tick();
         chk($sformatf("cclk@%0d", e), cclk_o, (e >= 10) ? 1 : ((e / 2) % 2));
         chk($sformatf("busy@%0d", e), busy_o, (e < 18) ? 1 : 0);
         chk($sformatf("stable@%0d", e), stable_o, (e >= 18) ? 1 : 0);
         chk($sformatf("done@%0d", e), done_o, (e == 18) ? 1 : 0);
      end
   endtask

   initial begin
      #3;
      chk("rst_cclk", cclk_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_stable", stable_o, 0);
      chk("rst_done", done_o, 0);
      #14 rst = 1'b0;
      tick();
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      chk("idle_release_busy", busy_o, 0);
      run_burst();
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("high_cclk", cclk_o, 1);
         chk("high_stable", stable_o, 1);
         chk("peer_not_early", peer_ready & ~stable_o, 0);
      end
      chk("peer_ready", peer_ready, 1);
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      chk("rel_cclk", cclk_o, 0);
      chk("rel_stable", stable_o, 0);
      chk("rel_busy", busy_o, 1);
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("low_start_ignored_busy", busy_o, 1);
      chk("low_start_ignored_cclk", cclk_o, 0);
      chk("peer_drop", peer_ready, 0);
      tick();
      chk("low_t3_busy", busy_o, 1);
      tick();
      chk("low_done_busy", busy_o, 0);
      pulse_start();
      chk("restart_busy", busy_o, 1);
      for (int e = 1; e <= 6; e++) tick();
      chk("abort_pre_cclk", cclk_o, 1);
      release_i = 1'b1;
      tick();
      release_i = 1'b0;
      for (int e = 7; e <= 13; e++) begin
         if (e > 7) tick();
         chk($sformatf("abort_cclk@%0d", e), cclk_o, 0);
         chk($sformatf("abort_done@%0d", e), done_o, 0);
         chk($sformatf("abort_busy@%0d", e), busy_o, (e < 11) ? 1 : 0);
      end
      pulse_start();
      for (int e = 1; e <= 13; e++) tick();
      chk("hold_cclk", cclk_o, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_cclk", cclk_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_stable", stable_o, 0);
      tick();
      #2 rst = 1'b0;
      tick();
      run_burst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
